// File: rtl/encoder_pkg.sv
// encoder_pkg: shared widths, FSM states and popcount helper for the 3-to-8 decoder / 8-to-3 encoder pair
package encoder_pkg;
    localparam int IDX_W = 3;
    localparam int BITS  = 8;
    typedef enum logic {STATE_IDLE, STATE_EMIT} state_t;
    function automatic logic [IDX_W:0] popcount(input logic [BITS-1:0] v);
        popcount = '0;
        for (int i = 0; i < BITS; i++) popcount += {{IDX_W{1'b0}}, v[i]};
    endfunction
endpackage

// File: rtl/prio_enc8.sv
// prio_enc8: combinational priority encoder; vec -> idx of lowest (MSB_FIRST=0) or highest (MSB_FIRST=1) set bit, any = vec!=0
module prio_enc8
    import encoder_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic [BITS-1:0]  vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    always_comb begin
        idx = '0;
        for (int i = 0; i < BITS; i++)
            if (vec[MSB_FIRST ? i : BITS-1-i]) idx = IDX_W'(MSB_FIRST ? i : BITS-1-i);
        any = |vec;
    end
endmodule

// File: rtl/bitmap_encoder8to3.sv
// bitmap_encoder8to3: accepts a bitmap (Data_in/in_valid/in_ready), emits each set-bit index (Data_out/out_valid/out_ready/last), reports count and zero_flag
module bitmap_encoder8to3
    import encoder_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BITS-1:0]  Data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDX_W-1:0] Data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             last,
    output logic [IDX_W:0]   count,
    output logic             zero_flag
);
    state_t          state;
    logic [BITS-1:0] pending;
    logic            any;
    prio_enc8 #(.MSB_FIRST(MSB_FIRST)) u_prio (
        .vec(pending),
        .idx(Data_out),
        .any(any)
    );
    assign in_ready  = state == STATE_IDLE;
    assign out_valid = state == STATE_EMIT;
    assign last      = out_valid && any && ((pending & (pending - 1'b1)) == '0);
    always_ff @(posedge clk) begin
        zero_flag <= 1'b0;
        if (rst) begin
            state   <= STATE_IDLE;
            pending <= '0;
            count   <= '0;
        end else if (in_ready && in_valid) begin
            pending   <= Data_in;
            count     <= popcount(Data_in);
            zero_flag <= Data_in == '0;
            state     <= Data_in == '0 ? STATE_IDLE : STATE_EMIT;
        end else if (out_valid && out_ready) begin
            pending <= pending & ~(BITS'(1) << Data_out);
            state   <= last ? STATE_IDLE : STATE_EMIT;
        end
    end
endmodule
